alu_multicycle: RTL and testbench

//  Parametrised successor of the single-cycle datapath ALU: registered result with valid/ready

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_iter_muldiv.sv | 110 +++++++++++
 rtl/alu_multicycle.sv | 144 ++++++++++++++
 tb/tb_alu_multicycle.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM encoding and op-class helpers for alu_multicycle
// Purpose: shared definitions for alu_multicycle and alu_iter_muldiv.
// Ports: none (package).
// Configuration: ALU_DIV_EN adds the DIV state and the divide op-class helper.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_MUL   = 4'b1000;
   localparam logic [3:0] ALU_MULHU = 4'b1001;
   localparam logic [3:0] ALU_DIVU  = 4'b1010;
   localparam logic [3:0] ALU_REMU  = 4'b1011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
`ifdef ALU_DIV_EN
      DIV  = 2'd2,
`endif
      DONE = 2'd3
   } aluState_t;

   function automatic logic isMulOp(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULHU);
   endfunction

`ifdef ALU_DIV_EN
   function automatic logic isDivOp(input logic [3:0] op);
      return (op == ALU_DIVU) || (op == ALU_REMU);
   endfunction
`endif

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - iterative shift-add multiplier and optional restoring divider
// Purpose: multi-cycle engine for MUL/MULHU (and DIVU/REMU when ALU_DIV_EN is defined).
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   StartMul            pulse: load operands and begin a multiply
//   StartDiv            pulse: load operands and begin a divide (ALU_DIV_EN only)
//   OperandA, OperandB  operands, sampled on a start pulse
//   LastStep            high while the final iteration is being computed
//   ResultLo, ResultHi  accumulator value after the current step (product lo/hi,
//                       or quotient/remainder); valid to capture when LastStep is high
// Configuration: ALU_DIV_EN includes the divider datapath and its start port.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH            = 32,
   parameter int MUL_BITS_PER_CYC = 1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             StartMul,
`ifdef ALU_DIV_EN
   input  logic             StartDiv,
`endif
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   output logic             LastStep,
   output logic [WIDTH-1:0] ResultLo,
   output logic [WIDTH-1:0] ResultHi
);

   localparam int K         = MUL_BITS_PER_CYC;
   localparam int MUL_STEPS = WIDTH / K;
   localparam int CW        = $clog2(WIDTH + 1);

   logic [CW-1:0]        countQ;
   logic [2*WIDTH-1:0]   accQ;
   logic [2*WIDTH-1:0]   accNext;
   logic [WIDTH-1:0]     opndQ;

   // Multiply: hi half accumulates partial products, lo half holds the
   // not-yet-consumed multiplier bits; both shift right K bits per step.
   logic [WIDTH+K-1:0]   addend;
   logic [WIDTH+K-1:0]   mulSum;
   logic [2*WIDTH-1:0]   mulNext;

   always_comb begin
      addend = '0;
      for (int i = 0; i < K; i++) begin
         if (accQ[i]) begin
            addend = addend + ({{K{1'b0}}, opndQ} << i);
         end
      end
      mulSum  = {{K{1'b0}}, accQ[2*WIDTH-1:WIDTH]} + addend;
      mulNext = {mulSum, accQ[WIDTH-1:K]};
   end

`ifdef ALU_DIV_EN
   // Restoring divide: hi half is the partial remainder, lo half shifts the
   // dividend out and the quotient in. Two guard bits keep the trial sign
   // correct even for a zero divisor, where the shifted remainder can reach
   // 2^WIDTH; that case then yields all-ones quotient and remainder = dividend.
   logic                 isDivQ;
   logic [WIDTH+1:0]     trial;
   logic [2*WIDTH-1:0]   divNext;

   always_comb begin
      trial = {1'b0, accQ[2*WIDTH-1:WIDTH-1]} - {2'b00, opndQ};
      if (!trial[WIDTH+1]) begin
         divNext = {trial[WIDTH-1:0], accQ[WIDTH-2:0], 1'b1};
      end else begin
         divNext = {accQ[2*WIDTH-2:0], 1'b0};
      end
   end

   assign accNext = isDivQ ? divNext : mulNext;
`else
   assign accNext = mulNext;
`endif

   assign LastStep = (countQ == CW'(1));
   assign ResultLo = accNext[WIDTH-1:0];
   assign ResultHi = accNext[2*WIDTH-1:WIDTH];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         countQ <= '0;
         accQ   <= '0;
         opndQ  <= '0;
`ifdef ALU_DIV_EN
         isDivQ <= 1'b0;
`endif
      end else if (StartMul) begin
         countQ <= CW'(MUL_STEPS);
         accQ   <= {{WIDTH{1'b0}}, OperandB};
         opndQ  <= OperandA;
`ifdef ALU_DIV_EN
         isDivQ <= 1'b0;
      end else if (StartDiv) begin
         countQ <= CW'(WIDTH);
         accQ   <= {{WIDTH{1'b0}}, OperandA};
         opndQ  <= OperandB;
         isDivQ <= 1'b1;
`endif
      end else if (countQ != '0) begin
         countQ <= countQ - CW'(1);
         accQ   <= accNext;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked ALU with registered result and iterative mul/div
// Purpose: execute-stage ALU; single-cycle logic/arith ops, multi-cycle MUL/MULHU
//          and (with ALU_DIV_EN) DIVU/REMU; stalls upstream through InReady.
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   ALUControl          op code, sampled on InValid && InReady
//   DataIn0, DataIn1    operands A/B, sampled on InValid && InReady
//   InValid / InReady   input handshake; InReady is high only in IDLE
//   DataOut, ZeroOut    registered result and (result == 0)
//   OutValid / OutReady output handshake; OutValid is high only in DONE
// Configuration: ALU_DIV_EN enables DIVU/REMU; otherwise they act as undefined codes.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH            = 32,
   parameter int MUL_BITS_PER_CYC = 1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] DataIn0,
   input  logic [WIDTH-1:0] DataIn1,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] DataOut,
   output logic             ZeroOut,
   output logic             OutValid,
   input  logic             OutReady
);

   aluState_t        stateQ, stateD;
   logic [3:0]       opQ;
   logic             accept;
   logic             startMul;
   logic             loadRes;
   logic [WIDTH-1:0] resD;
   logic [WIDTH-1:0] simpleRes;
   logic             iterLast;
   logic [WIDTH-1:0] iterLo, iterHi;

   assign InReady  = (stateQ == IDLE);
   assign OutValid = (stateQ == DONE);
   assign accept   = InValid && InReady;
   assign startMul = accept && isMulOp(ALUControl);

`ifdef ALU_DIV_EN
   logic startDiv;
   assign startDiv = accept && isDivOp(ALUControl);
`endif

   always_comb begin
      case (ALUControl)
         ALU_AND: simpleRes = DataIn0 & DataIn1;
         ALU_OR:  simpleRes = DataIn0 | DataIn1;
         ALU_ADD: simpleRes = DataIn0 + DataIn1;
         ALU_SUB: simpleRes = DataIn0 - DataIn1;
         ALU_SLT: simpleRes = {{(WIDTH-1){1'b0}}, ($signed(DataIn0) < $signed(DataIn1))};
         ALU_NOR: simpleRes = ~(DataIn0 | DataIn1);
         default: simpleRes = '0;
      endcase
   end

   alu_iter_muldiv #(
      .WIDTH            (WIDTH),
      .MUL_BITS_PER_CYC (MUL_BITS_PER_CYC)
   ) uIter (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .StartMul (startMul),
`ifdef ALU_DIV_EN
      .StartDiv (startDiv),
`endif
      .OperandA (DataIn0),
      .OperandB (DataIn1),
      .LastStep (iterLast),
      .ResultLo (iterLo),
      .ResultHi (iterHi)
   );

   always_comb begin
      stateD  = stateQ;
      loadRes = 1'b0;
      resD    = simpleRes;
      case (stateQ)
         IDLE: begin
            if (InValid) begin
               if (isMulOp(ALUControl)) begin
                  stateD = MUL;
`ifdef ALU_DIV_EN
               end else if (isDivOp(ALUControl)) begin
                  stateD = DIV;
`endif
               end else begin
                  stateD  = DONE;
                  loadRes = 1'b1;
               end
            end
         end
         MUL: begin
            if (iterLast) begin
               stateD  = DONE;
               loadRes = 1'b1;
               resD    = (opQ == ALU_MULHU) ? iterHi : iterLo;
            end
         end
`ifdef ALU_DIV_EN
         DIV: begin
            if (iterLast) begin
               stateD  = DONE;
               loadRes = 1'b1;
               resD    = (opQ == ALU_REMU) ? iterHi : iterLo;
            end
         end
`endif
         DONE: begin
            if (OutReady) begin
               stateD = IDLE;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         stateQ  <= IDLE;
         opQ     <= '0;
         DataOut <= '0;
         ZeroOut <= 1'b1;
      end else begin
         stateQ <= stateD;
         if (accept) begin
            opQ <= ALUControl;
         end
         // Result registers only change when a new result lands, so they hold
         // through backpressure and keep their value after the handshake.
         if (loadRes) begin
            DataOut <= resD;
            ZeroOut <= (resD == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle (WIDTH=32, 1 bit/cycle)
// Ports: none (top-level bench). Define ALU_DIV_EN to exercise the divider.
module tb_alu_multicycle;

   logic        Clk;
   logic        Reset_n;
   logic [3:0]  ALUControl;
   logic [31:0] DataIn0, DataIn1;
   logic        InValid, InReady;
   logic [31:0] DataOut;
   logic        ZeroOut, OutValid, OutReady;

   int checks = 0;
   int errors = 0;

   alu_multicycle #(.WIDTH(32), .MUL_BITS_PER_CYC(1)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .ALUControl (ALUControl),
      .DataIn0    (DataIn0),
      .DataIn1    (DataIn1),
      .InValid    (InValid),
      .InReady    (InReady),
      .DataOut    (DataOut),
      .ZeroOut    (ZeroOut),
      .OutValid   (OutValid),
      .OutReady   (OutReady)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Issues one op and waits for its result; caller sits at posedge+1.
   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat, output int leak);
      int guard;
      guard = 0;
      while (!InReady && guard < 200) begin
         @(posedge Clk); #1; guard++;
      end
      ALUControl = op; DataIn0 = a; DataIn1 = b; InValid = 1'b1;
      @(posedge Clk); #1;
      InValid = 1'b0;
      lat = 1; leak = 0;
      while (!OutValid && lat < 100) begin
         if (InReady) leak++;
         @(posedge Clk); #1; lat++;
      end
      res = DataOut; z = ZeroOut;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      ALUControl = 4'b0000; DataIn0 = '0; DataIn1 = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk); Reset_n = 1'b1;
      @(posedge Clk); #1;
      checks++; if (DataOut !== 32'd0) begin errors++; $display("FAIL reset_dataout got %h want 0", DataOut); end
      checks++; if (ZeroOut !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", ZeroOut); end
      checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b want 0", OutValid); end
      checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %b want 1", InReady); end
   endtask

   task automatic test_simple_ops();
      logic [3:0]  ops [10];
      logic [31:0] as  [10];
      logic [31:0] bs  [10];
      logic [31:0] exp [10];
      logic [31:0] res;
      logic        z;
      int          lat, leak;
      ops[0] = 4'b0010; as[0] = 32'd1;          bs[0] = 32'd2;      exp[0] = 32'd3;
      ops[1] = 4'b0110; as[1] = 32'd4;          bs[1] = 32'd4;      exp[1] = 32'd0;
      ops[2] = 4'b0111; as[2] = 32'd1;          bs[2] = 32'd2;      exp[2] = 32'd1;
      ops[3] = 4'b0111; as[3] = 32'd4;          bs[3] = 32'd2;      exp[3] = 32'd0;
      ops[4] = 4'b0111; as[4] = 32'hFFFFFFFF;   bs[4] = 32'd1;      exp[4] = 32'd1;
      ops[5] = 4'b0101; as[5] = 32'd9;          bs[5] = 32'd3;      exp[5] = 32'd0;
      ops[6] = 4'b0000; as[6] = 32'h0000F0F0;   bs[6] = 32'h0000FF00; exp[6] = 32'h0000F000;
      ops[7] = 4'b0001; as[7] = 32'h0000F0F0;   bs[7] = 32'h0000FF00; exp[7] = 32'h0000FFF0;
      ops[8] = 4'b1100; as[8] = 32'd0;          bs[8] = 32'd0;      exp[8] = 32'hFFFFFFFF;
      ops[9] = 4'b0010; as[9] = 32'hFFFFFFFF;   bs[9] = 32'd1;      exp[9] = 32'd0;
      for (int i = 0; i < 10; i++) begin
         runOp(ops[i], as[i], bs[i], res, z, lat, leak);
         checks++; if (res !== exp[i]) begin errors++; $display("FAIL simple_res[%0d] got %h want %h", i, res, exp[i]); end
         checks++; if (z !== (exp[i] == 32'd0)) begin errors++; $display("FAIL simple_zero[%0d] got %b want %b", i, z, exp[i] == 32'd0); end
         checks++; if (lat !== 1) begin errors++; $display("FAIL simple_latency[%0d] got %0d want 1", i, lat); end
      end
   endtask

   task automatic test_mul();
      logic [3:0]  ops [3];
      logic [31:0] as  [3];
      logic [31:0] bs  [3];
      logic [31:0] exp [3];
      logic [31:0] res;
      logic        z;
      int          lat, leak;
      ops[0] = 4'b1000; as[0] = 32'h00010000; bs[0] = 32'h00010000; exp[0] = 32'd0;
      ops[1] = 4'b1001; as[1] = 32'h00010000; bs[1] = 32'h00010000; exp[1] = 32'd1;
      ops[2] = 4'b1000; as[2] = 32'hFFFFFFFF; bs[2] = 32'hFFFFFFFF; exp[2] = 32'd1;
      for (int i = 0; i < 3; i++) begin
         runOp(ops[i], as[i], bs[i], res, z, lat, leak);
         checks++; if (res !== exp[i]) begin errors++; $display("FAIL mul_res[%0d] got %h want %h", i, res, exp[i]); end
         checks++; if (z !== (exp[i] == 32'd0)) begin errors++; $display("FAIL mul_zero[%0d] got %b want %b", i, z, exp[i] == 32'd0); end
         checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency[%0d] got %0d want 33", i, lat); end
         checks++; if (leak !== 0) begin errors++; $display("FAIL mul_inready_busy[%0d] got %0d cycles want 0", i, leak); end
      end
      // MULHU of all-ones: (2^32-1)^2 high word = 0xFFFFFFFE
      runOp(4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, res, z, lat, leak);
      checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_ones got %h want fffffffe", res); end
   endtask

   task automatic test_backpressure();
      int guard;
      guard = 0;
      while (!InReady && guard < 200) begin @(posedge Clk); #1; guard++; end
      OutReady = 1'b0;
      ALUControl = 4'b0010; DataIn0 = 32'd7; DataIn1 = 32'd8; InValid = 1'b1;
      @(posedge Clk); #1;
      DataIn0 = 32'd1; DataIn1 = 32'd1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({OutValid, InReady, DataOut} !== {1'b1, 1'b0, 32'd15}) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v=%b r=%b d=%h want v=1 r=0 d=0000000f", i, OutValid, InReady, DataOut);
         end
         @(posedge Clk); #1;
      end
      OutReady = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if ({OutValid, InReady, DataOut} !== {1'b0, 1'b1, 32'd15}) begin
         errors++;
         $display("FAIL bp_release got v=%b r=%b d=%h want v=0 r=1 d=0000000f", OutValid, InReady, DataOut);
      end
      @(posedge Clk); #1;
      InValid = 1'b0;
      checks++;
      if ({OutValid, DataOut} !== {1'b1, 32'd2}) begin
         errors++;
         $display("FAIL bp_next_accept got v=%b d=%h want v=1 d=00000002", OutValid, DataOut);
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_reset_midop();
      logic [31:0] res;
      logic        z;
      int          lat, leak, guard, stale;
      guard = 0;
      while (!InReady && guard < 200) begin @(posedge Clk); #1; guard++; end
      ALUControl = 4'b1000; DataIn0 = 32'd3; DataIn1 = 32'd5; InValid = 1'b1;
      @(posedge Clk); #1;
      InValid = 1'b0;
      repeat (9) @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rst_mid_outvalid got %b want 0", OutValid); end
      checks++; if (DataOut !== 32'd0) begin errors++; $display("FAIL rst_mid_dataout got %h want 0", DataOut); end
      checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rst_mid_inready got %b want 1", InReady); end
      @(negedge Clk); Reset_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clk); #1;
         if (OutValid) stale++;
      end
      checks++; if (stale !== 0) begin errors++; $display("FAIL rst_mid_stale got %0d valid cycles want 0", stale); end
      runOp(4'b0010, 32'd1, 32'd2, res, z, lat, leak);
      checks++; if (res !== 32'd3) begin errors++; $display("FAIL rst_mid_add got %h want 3", res); end
   endtask

`ifdef ALU_DIV_EN
   task automatic test_div();
      logic [3:0]  ops [4];
      logic [31:0] as  [4];
      logic [31:0] bs  [4];
      logic [31:0] exp [4];
      logic [31:0] res;
      logic        z;
      int          lat, leak;
      ops[0] = 4'b1010; as[0] = 32'd100; bs[0] = 32'd7; exp[0] = 32'd14;
      ops[1] = 4'b1011; as[1] = 32'd100; bs[1] = 32'd7; exp[1] = 32'd2;
      ops[2] = 4'b1010; as[2] = 32'd7;   bs[2] = 32'd0; exp[2] = 32'hFFFFFFFF;
      ops[3] = 4'b1011; as[3] = 32'd7;   bs[3] = 32'd0; exp[3] = 32'd7;
      for (int i = 0; i < 4; i++) begin
         runOp(ops[i], as[i], bs[i], res, z, lat, leak);
         checks++; if (res !== exp[i]) begin errors++; $display("FAIL div_res[%0d] got %h want %h", i, res, exp[i]); end
         checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency[%0d] got %0d want 33", i, lat); end
         checks++; if (leak !== 0) begin errors++; $display("FAIL div_inready_busy[%0d] got %0d want 0", i, leak); end
      end
   endtask
`else
   task automatic test_div();
      logic [31:0] res;
      logic        z;
      int          lat, leak;
      runOp(4'b1010, 32'd100, 32'd7, res, z, lat, leak);
      checks++; if (res !== 32'd0) begin errors++; $display("FAIL nodiv_res got %h want 0", res); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL nodiv_zero got %b want 1", z); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL nodiv_latency got %0d want 1", lat); end
   endtask
`endif

   initial begin
      test_reset();
      test_simple_ops();
      test_mul();
      test_backpressure();
      test_reset_midop();
      test_div();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
